// File: rtl/magnitude_estimator_seq_pkg.sv
// Shared definitions for the abs/min/max functional-unit initiators and the
// magnitude-estimator sequencer.
package magnitude_estimator_seq_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ABS  = 2'b01;
  localparam logic [1:0] OP_MIN  = 2'b10;
  localparam logic [1:0] OP_MAX  = 2'b11;

  localparam logic [WIDTH-1:0] ABS_OVF = 16'h8000;
  localparam logic [WIDTH-1:0] ABS_SAT = 16'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSX,
    ST_ABSY,
    ST_MIN,
    ST_MAX,
    ST_DONE
  } state_t;

  // abs(-32768) wraps back to 0x8000; clamp it so later signed min/max see a positive value
  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] m);
    return (m == ABS_OVF) ? ABS_SAT : m;
  endfunction

endpackage

// File: rtl/magnitude_estimator_seq_if.sv
// Operand/result handshakes plus the (A, B, Op) -> M functional-unit bus.
// master: the sequencer; slave: the surrounding client and the functional unit.
interface magnitude_estimator_seq_if;
  import magnitude_estimator_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mag;
  logic [WIDTH-1:0] fu_a;
  logic [WIDTH-1:0] fu_b;
  logic [1:0]       fu_op;
  logic [WIDTH-1:0] fu_m;

  modport master (
    input  in_valid, in_x, in_y, out_ready, fu_m,
    output in_ready, out_valid, out_mag, fu_a, fu_b, fu_op
  );

  modport slave (
    output in_valid, in_x, in_y, out_ready, fu_m,
    input  in_ready, out_valid, out_mag, fu_a, fu_b, fu_op
  );

endinterface

// File: rtl/magnitude_estimator_seq.sv
// Alpha-max-plus-beta-min sequencer: |v| ~= max(|x|,|y|) + min(|x|,|y|)/2,
// issuing one operation per cycle to the shared abs/min/max unit.
module magnitude_estimator_seq
  import magnitude_estimator_seq_pkg::*;
(
  input logic                       clk,
  input logic                       rst,
  magnitude_estimator_seq_if.master bus
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] ax_q;
  logic [WIDTH-1:0] ay_q;
  logic [WIDTH-2:0] mn_half_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] fu_a_q;
  logic [WIDTH-1:0] fu_b_q;
  logic [1:0]       fu_op_q;
  logic [WIDTH-1:0] fu_a_nx;
  logic [WIDTH-1:0] fu_b_nx;
  logic [1:0]       fu_op_nx;

  // FU operands are registered, so they are decoded for the state being entered.
  // X is never stored separately: it rides in the fu_b register during ABSX.
  always_comb begin
    state_nx = state;
    fu_a_nx  = '0;
    fu_b_nx  = '0;
    fu_op_nx = OP_PASS;
    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nx = ST_ABSX;
          fu_op_nx = OP_ABS;
          fu_b_nx  = bus.in_x;
        end
      end
      ST_ABSX: begin
        state_nx = ST_ABSY;
        fu_op_nx = OP_ABS;
        fu_b_nx  = y_q;
      end
      ST_ABSY: begin
        state_nx = ST_MIN;
        fu_op_nx = OP_MIN;
        fu_a_nx  = ax_q;
        fu_b_nx  = sat_abs(bus.fu_m);
      end
      ST_MIN: begin
        state_nx = ST_MAX;
        fu_op_nx = OP_MAX;
        fu_a_nx  = ax_q;
        fu_b_nx  = ay_q;
      end
      ST_MAX: begin
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fu_a_q    <= '0;
      fu_b_q    <= '0;
      fu_op_q   <= OP_PASS;
      y_q       <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      mn_half_q <= '0;
      mag_q     <= '0;
    end else begin
      state   <= state_nx;
      fu_a_q  <= fu_a_nx;
      fu_b_q  <= fu_b_nx;
      fu_op_q <= fu_op_nx;
      case (state)
        ST_IDLE: if (bus.in_valid) y_q <= bus.in_y;
        ST_ABSX: ax_q <= sat_abs(bus.fu_m);
        ST_ABSY: ay_q <= sat_abs(bus.fu_m);
        ST_MIN:  mn_half_q <= bus.fu_m[WIDTH-1:1];
        // Both terms are at most 0x7FFF and 0x3FFF, so the 16-bit sum cannot wrap
        ST_MAX:  mag_q <= bus.fu_m + {1'b0, mn_half_q};
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_mag   = mag_q;
  assign bus.fu_a      = fu_a_q;
  assign bus.fu_b      = fu_b_q;
  assign bus.fu_op     = fu_op_q;

endmodule

// File: tb/tb_magnitude_estimator_seq.sv
// Directed bench for magnitude_estimator_seq; the abs/min/max unit is modelled
// here so the sequencer sees a realistic combinational fu_m.
module tb_magnitude_estimator_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  magnitude_estimator_seq_if bus_if ();

  magnitude_estimator_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] fu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a;
      2'b01:   return b[15] ? (16'd0 - b) : b;
      2'b10:   return ($signed(a) < $signed(b)) ? a : b;
      default: return ($signed(a) > $signed(b)) ? a : b;
    endcase
  endfunction

  assign bus_if.fu_m = fu_model(bus_if.fu_op, bus_if.fu_a, bus_if.fu_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; reports result, cycles from accept edge and whether it arrived.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] mag, output int lat, output bit got);
    bus_if.in_valid  = 1'b1;
    bus_if.in_x      = x;
    bus_if.in_y      = y;
    bus_if.out_ready = 1'b0;
    tick();
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = bus_if.out_valid;
    mag = bus_if.out_mag;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_x      = '0;
    bus_if.in_y      = '0;
    bus_if.out_ready = 1'b0;
    #2;
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus_if.in_ready); end
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus_if.out_valid); end
    total++; if (bus_if.out_mag !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out_mag got=%h want=0000", bus_if.out_mag); end
    total++; if (bus_if.fu_op !== 2'b00) begin bad++; $display("[TB] FAIL reset_fu_op got=%b want=00", bus_if.fu_op); end
    total++; if (bus_if.fu_a !== 16'h0000) begin bad++; $display("[TB] FAIL reset_fu_a got=%h want=0000", bus_if.fu_a); end
    total++; if (bus_if.fu_b !== 16'h0000) begin bad++; $display("[TB] FAIL reset_fu_b got=%h want=0000", bus_if.fu_b); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    bus_if.in_valid  = 1'b1;
    bus_if.in_x      = 16'd3;
    bus_if.in_y      = 16'hFFFC;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_in_ready got=%b want=0", bus_if.in_ready); end
    total++; if (bus_if.fu_op !== 2'b01 || bus_if.fu_b !== 16'd3) begin bad++; $display("[TB] FAIL basic_c1 got op=%b b=%h want op=01 b=0003", bus_if.fu_op, bus_if.fu_b); end
    tick();
    total++; if (bus_if.fu_op !== 2'b01 || bus_if.fu_b !== 16'hFFFC) begin bad++; $display("[TB] FAIL basic_c2 got op=%b b=%h want op=01 b=fffc", bus_if.fu_op, bus_if.fu_b); end
    tick();
    total++; if (bus_if.fu_op !== 2'b10 || bus_if.fu_a !== 16'd3 || bus_if.fu_b !== 16'd4) begin bad++; $display("[TB] FAIL basic_c3 got op=%b a=%h b=%h want op=10 a=0003 b=0004", bus_if.fu_op, bus_if.fu_a, bus_if.fu_b); end
    tick();
    total++; if (bus_if.fu_op !== 2'b11 || bus_if.fu_a !== 16'd3 || bus_if.fu_b !== 16'd4) begin bad++; $display("[TB] FAIL basic_c4 got op=%b a=%h b=%h want op=11 a=0003 b=0004", bus_if.fu_op, bus_if.fu_a, bus_if.fu_b); end
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%b want=0", bus_if.out_valid); end
    tick();
    total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_mag !== 16'd5) begin bad++; $display("[TB] FAIL basic_c5 got valid=%b mag=%h want valid=1 mag=0005", bus_if.out_valid, bus_if.out_mag); end
    total++; if (bus_if.fu_op !== 2'b00 || bus_if.fu_a !== 16'h0 || bus_if.fu_b !== 16'h0) begin bad++; $display("[TB] FAIL basic_done_fu got op=%b a=%h b=%h want all 0", bus_if.fu_op, bus_if.fu_a, bus_if.fu_b); end
    tick();
    total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_back_idle got rdy=%b valid=%b want rdy=1 valid=0", bus_if.in_ready, bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_saturation;
    logic [15:0] xs [2];
    logic [15:0] ys [2];
    logic [15:0] mag;
    int          lat;
    bit          got;
    xs = '{16'h8000, 16'h0000};
    ys = '{16'h0000, 16'h8000};
    for (int i = 0; i < 2; i++) begin
      do_op(xs[i], ys[i], mag, lat, got);
      total++; if (!got || mag !== 16'h7FFF) begin bad++; $display("[TB] FAIL saturation_%0d got arrived=%0d mag=%h want mag=7fff", i, got, mag); end
      total++; if (lat !== 5) begin bad++; $display("[TB] FAIL saturation_latency_%0d got=%0d want=5", i, lat); end
    end
  endtask

  task automatic test_no_wrap;
    logic [15:0] xs [2];
    logic [15:0] ys [2];
    logic [15:0] mag;
    int          lat;
    bit          got;
    xs = '{16'h7FFF, 16'h8000};
    ys = '{16'h8001, 16'h8000};
    for (int i = 0; i < 2; i++) begin
      do_op(xs[i], ys[i], mag, lat, got);
      total++; if (!got || mag !== 16'hBFFE) begin bad++; $display("[TB] FAIL no_wrap_%0d got arrived=%0d mag=%h want mag=bffe", i, got, mag); end
    end
  endtask

  task automatic test_mixed_signs;
    logic [15:0] xs  [4];
    logic [15:0] ys  [4];
    logic [15:0] exp_mag [4];
    logic [15:0] mag;
    int          lat;
    bit          got;
    xs      = '{16'hFFFB, 16'd100,  16'hFFFF, 16'h1000};
    ys      = '{16'hFFF4, 16'hFFF9, 16'h0001, 16'h0800};
    exp_mag = '{16'd14,   16'd103,  16'd1,    16'h1400};
    for (int i = 0; i < 4; i++) begin
      do_op(xs[i], ys[i], mag, lat, got);
      total++; if (!got || mag !== exp_mag[i]) begin bad++; $display("[TB] FAIL mixed_%0d got arrived=%0d mag=%h want mag=%h", i, got, mag, exp_mag[i]); end
    end
  endtask

  task automatic test_backpressure;
    bus_if.in_valid  = 1'b1;
    bus_if.in_x      = 16'h0000;
    bus_if.in_y      = 16'h0000;
    bus_if.out_ready = 1'b0;
    tick();
    bus_if.in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_mag !== 16'h0000) begin bad++; $display("[TB] FAIL backpressure_hold_%0d got valid=%b mag=%h want valid=1 mag=0000", i, bus_if.out_valid, bus_if.out_mag); end
      total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL backpressure_in_ready_%0d got=%b want=0", i, bus_if.in_ready); end
      bus_if.in_valid = (i % 2 == 0);
      bus_if.in_x     = 16'h1234;
      bus_if.in_y     = 16'h0567;
      tick();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL backpressure_release got rdy=%b valid=%b want rdy=1 valid=0", bus_if.in_ready, bus_if.out_valid); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] mag;
    int          lat;
    bit          got;
    bit          stray;
    bus_if.in_valid  = 1'b1;
    bus_if.in_x      = 16'h0100;
    bus_if.in_y      = 16'h0200;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    tick();
    total++; if (bus_if.fu_op !== 2'b10) begin bad++; $display("[TB] FAIL reset_mid_in_min got op=%b want=10", bus_if.fu_op); end
    rst = 1'b1;
    #1;
    total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.fu_op !== 2'b00) begin bad++; $display("[TB] FAIL reset_mid_async got rdy=%b valid=%b op=%b want rdy=1 valid=0 op=00", bus_if.in_ready, bus_if.out_valid, bus_if.fu_op); end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_if.out_valid) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("[TB] FAIL reset_mid_no_pulse got stray_valid=%b want=0", stray); end
    do_op(16'd6, 16'd8, mag, lat, got);
    total++; if (!got || mag !== 16'd11) begin bad++; $display("[TB] FAIL reset_mid_fresh got arrived=%0d mag=%h want mag=000b", got, mag); end
  endtask

  task automatic test_back_to_back;
    int          acc [2];
    logic [15:0] mags [2];
    int          n_acc;
    int          n_mag;
    bit          accepted;
    n_acc = 0;
    n_mag = 0;
    acc   = '{0, 0};
    mags  = '{16'h0, 16'h0};
    bus_if.in_valid  = 1'b1;
    bus_if.in_x      = 16'd3;
    bus_if.in_y      = 16'hFFFC;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 30 && n_mag < 2; i++) begin
      accepted = 1'b0;
      if (bus_if.in_ready && bus_if.in_valid && n_acc < 2) begin
        acc[n_acc] = i;
        n_acc++;
        accepted = 1'b1;
      end
      tick();
      if (accepted && n_acc == 1) begin
        bus_if.in_x = 16'd6;
        bus_if.in_y = 16'd8;
      end else if (accepted) begin
        bus_if.in_valid = 1'b0;
      end
      if (bus_if.out_valid && n_mag < 2) begin
        mags[n_mag] = bus_if.out_mag;
        n_mag++;
      end
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    total++; if (n_acc !== 2 || n_mag !== 2) begin bad++; $display("[TB] FAIL b2b_counts got acc=%0d res=%0d want 2 and 2", n_acc, n_mag); end
    total++; if (acc[1] - acc[0] !== 6) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=6", acc[1] - acc[0]); end
    total++; if (mags[0] !== 16'd5) begin bad++; $display("[TB] FAIL b2b_first got=%h want=0005", mags[0]); end
    total++; if (mags[1] !== 16'd11) begin bad++; $display("[TB] FAIL b2b_second got=%h want=000b", mags[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_no_wrap();
    test_mixed_signs();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/magnitude_estimator_seq.md
# magnitude_estimator_seq

Sequential controller that issues operations to the shared 16-bit abs/min/max functional unit and consumes its results. It computes the alpha-max-plus-beta-min magnitude estimate |v| ≈ max(|x|,|y|) + min(|x|,|y|)/2 for a signed 2-D vector. It sits upstream of the square-root datapath as a cheap hypotenuse approximation, and is the initiator side of the functional unit's (A, B, Op) → M interface. The unit is time-shared, so the block issues exactly one operation per cycle, accepts new work through a valid/ready handshake, and holds its result under output backpressure.

## Interface
- No parameters; width fixed at 16 bits.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  X/Y operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- in_x  in  16  signed two's-complement X.
- in_y  in  16  signed two's-complement Y.
- out_valid  out  1  estimate valid; held until accepted.
- out_ready  in  1  downstream accepts estimate.
- out_mag  out  16  unsigned magnitude estimate.
- fu_a  out  16  functional-unit operand A.
- fu_b  out  16  functional-unit operand B.
- fu_op  out  2  functional-unit opcode.
- fu_m  in  16  functional-unit result (combinational, same cycle).

## Operation
- Opcodes:
  - 00 = pass A
  - 01 = abs(B)
  - 10 = signed min(A,B)
  - 11 = signed max(A,B)
- States IDLE → ABSX → ABSY → MIN → MAX → DONE → IDLE. One state per cycle except DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_x and in_y into internal registers and go to ABSX.
- ABSX: fu_op=01, fu_b=X. Capture fu_m into AX.
- ABSY: fu_op=01, fu_b=Y. Capture fu_m into AY.
- Abs saturation: if fu_m==16'h8000 (abs of −32768), store 16'h7FFF. This keeps AX and AY in 0..32767 so the signed min/max operate correctly.
- MIN: fu_op=10, fu_a=AX, fu_b=AY. Capture MN.
- MAX: fu_op=11, fu_a=AX, fu_b=AY. Capture MX.
- Result register: on the MAX cycle, out_mag ← fu_m + (MN >> 1). The shift is logical and truncating; the sum is unsigned.
  - Maximum value is 0x7FFF + 0x3FFF = 0xBFFE, so there is no overflow and no 17th bit.
- DONE: out_valid=1, out_mag stable. On out_ready, go to IDLE.
- Outputs in IDLE and DONE: fu_op=00, fu_a=0, fu_b=0. Operands are don't-care to the FU but must be driven to 0.
- in_valid outside IDLE is ignored; operands are not sampled.
- out_ready while out_valid=0 is ignored.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - out_mag=0
  - fu_a=0, fu_b=0, fu_op=00
  - X, Y, AX, AY, MN all 0
- Latency: accept edge at cycle 0; ABSX, ABSY, MIN and MAX occupy cycles 1–4; out_valid rises at cycle 5.
- Throughput: at best 6 cycles per result. The DONE→IDLE handshake edge is followed by at least one IDLE cycle before the next accept. There is no same-cycle out/in overlap.
- Backpressure: while out_ready=0, out_valid and out_mag hold indefinitely and in_ready stays 0.
- All fu_* outputs are registered, decoded from state and the internal registers. fu_m is sampled at the end of the same cycle the opcode is presented; the FU is purely combinational.
- Reset asserted mid-operation: immediately forces the reset values above (asynchronous). The partial computation is discarded and no out_valid pulse is produced.

## Structure
- Shared package holds:
  - opcode constants OP_PASS=2'b00, OP_ABS=2'b01, OP_MIN=2'b10, OP_MAX=2'b11 (shared with the FU and other initiators)
  - the state enum
  - the 16'h8000 / 16'h7FFF saturation constants
- Sub-module magnitude_estimator_top: instantiates this sequencer plus the abs/min/max FU, wiring fu_a/fu_b/fu_op/fu_m. The bench targets the top; the sequencer alone is ~150–250 lines.

## Test plan
- X=3, Y=−4 (0xFFFC) → fu_op sequence 01,01,10,11 on cycles 1–4. AX=3, AY=4, MN=3, MX=4. out_mag=5 at cycle 5.
- X=−32768, Y=0 → AX saturates to 0x7FFF. out_mag=0x7FFF.
- X=0x7FFF, Y=0x8001 → AX=AY=0x7FFF. out_mag=0xBFFE, with no wrap.
- Backpressure: X=0, Y=0, hold out_ready=0 for 10 cycles → out_valid=1 and out_mag=0 stable throughout. in_ready=0 throughout, and in_valid pulses are ignored. Then out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst during the MIN state → same-cycle in_ready=1, out_valid=0, fu_op=00. After release, a fresh X=6, Y=8 → out_mag=11.
- Back-to-back: in_valid held high with two operand pairs and out_ready=1 → second accept occurs exactly 6 cycles after the first; both results are correct.
